sobel_grad_pipe: RTL and testbench

//  Parametrised, pipelined successor to the combinational Sobel core.

---
 rtl/sobel_pkg.sv | 34 +++
 rtl/sobel_grad_kernel.sv | 43 ++++
 rtl/sobel_grad_pipe.sv | 130 +++++++++++++
 tb/tb_sobel_grad_pipe.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel gradient pipeline.
// Window layout: rows v0..v2, pixels p0..p2, v0.p0 in the LSBs.
package sobel_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic [1:0] {
    MODE_L1     = 2'd0,
    MODE_MAX    = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_RSVD   = 2'd3
  } sobel_mode_e;

  function automatic int grad_width(input int w);
    return w + 3;
  endfunction

  localparam int GRAD_WIDTH = grad_width(PIX_W_DEF);

  typedef logic [PIX_W_DEF-1:0] sobel_pix_t;

  typedef struct packed {
    sobel_pix_t p2;
    sobel_pix_t p1;
    sobel_pix_t p0;
  } sobel_row_t;

  typedef struct packed {
    sobel_row_t v2;
    sobel_row_t v1;
    sobel_row_t v0;
  } sobel_win_t;

endpackage

// File: rtl/sobel_grad_kernel.sv
// Combinational Sobel X/Y gradients of one 3x3 window.
// Pixels are zero-extended into GW-bit signed before the sums.
module sobel_grad_kernel
  import sobel_pkg::*;
#(
  parameter  int W  = 8,
  localparam int GW = W + 3
) (
  input  logic [9*W-1:0]        win,
  output logic signed [GW-1:0]  gx,
  output logic signed [GW-1:0]  gy
);

  typedef logic [W-1:0] px_t;

  typedef struct packed {
    px_t p2;
    px_t p1;
    px_t p0;
  } row_t;

  typedef struct packed {
    row_t v2;
    row_t v1;
    row_t v0;
  } win_t;

  win_t w;
  assign w = win;

  function automatic logic signed [GW-1:0] ext(input px_t p);
    return $signed(GW'({3'b000, p}));
  endfunction

  assign gx = (ext(w.v0.p2) - ext(w.v0.p0))
            + ((ext(w.v1.p2) - ext(w.v1.p0)) <<< 1)
            + (ext(w.v2.p2) - ext(w.v2.p0));

  assign gy = (ext(w.v2.p0) - ext(w.v0.p0))
            + ((ext(w.v2.p1) - ext(w.v0.p1)) <<< 1)
            + (ext(w.v2.p2) - ext(w.v0.p2));

endmodule

// File: rtl/sobel_grad_pipe.sv
// Three-stage Sobel gradient pipeline with valid/ready on both
// sides, selectable output mode and a saturating edge counter.
module sobel_grad_pipe
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH_IN  = 8,
  parameter int PIXEL_WIDTH_OUT = 8,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [9*PIXEL_WIDTH_IN-1:0]  win_i,
  input  logic [1:0]                   mode_i,
  input  logic [PIXEL_WIDTH_OUT-1:0]   thresh_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [PIXEL_WIDTH_OUT-1:0]   out_pix_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  input  logic                         clr_cnt_i,
  output logic [CNT_WIDTH-1:0]         edge_cnt_o
);

  localparam int GW = grad_width(PIXEL_WIDTH_IN);
  localparam int PO = PIXEL_WIDTH_OUT;

  logic                 v1, v2, v3;
  logic                 rdy1, rdy2, rdy3;
  logic signed [GW-1:0] gx, gy, gx1, gy1;
  sobel_mode_e          m1, m2;
  logic [PO-1:0]        t1, t2;
  logic [GW-1:0]        ax, ay, mag, mag2;
  logic [PO-1:0]        sat, pix;
  logic                 hit, edge3;
  logic [CNT_WIDTH-1:0] cnt;

  // Ready ripples back from the output so bubbles collapse.
  assign rdy3       = out_ready_i | ~v3;
  assign rdy2       = rdy3 | ~v2;
  assign rdy1       = rdy2 | ~v1;
  assign in_ready_o = rdy1;

  sobel_grad_kernel #(
    .W (PIXEL_WIDTH_IN)
  ) u_kernel (
    .win (win_i),
    .gx  (gx),
    .gy  (gy)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1  <= 1'b0;
      gx1 <= '0;
      gy1 <= '0;
      m1  <= MODE_L1;
      t1  <= '0;
    end else if (rdy1) begin
      v1  <= in_valid_i;
      gx1 <= gx;
      gy1 <= gy;
      m1  <= sobel_mode_e'(mode_i);
      t1  <= thresh_i;
    end
  end

  assign ax = gx1[GW-1] ? -gx1 : gx1;
  assign ay = gy1[GW-1] ? -gy1 : gy1;

  always_comb begin
    mag = ax + ay;
    unique case (1'b1)
      (m1 == MODE_MAX): mag = (ax > ay) ? ax : ay;
      default:          mag = ax + ay;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v2   <= 1'b0;
      mag2 <= '0;
      m2   <= MODE_L1;
      t2   <= '0;
    end else if (rdy2) begin
      v2   <= v1;
      mag2 <= mag;
      m2   <= m1;
      t2   <= t1;
    end
  end

  assign sat = (|mag2[GW-1:PO]) ? '1 : mag2[PO-1:0];
  assign hit = (sat >= t2);

  always_comb begin
    pix = sat;
    unique case (1'b1)
      (m2 == MODE_THRESH): pix = hit ? '1 : '0;
      default:             pix = sat;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v3        <= 1'b0;
      out_pix_o <= '0;
      edge3     <= 1'b0;
    end else if (rdy3) begin
      v3        <= v2;
      out_pix_o <= pix;
      edge3     <= hit;
    end
  end

  assign out_valid_o = v3;

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clr_cnt_i) begin
      cnt <= '0;
    end else if (v3 && out_ready_i && edge3 && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign edge_cnt_o = cnt;

endmodule

// File: tb/tb_sobel_grad_pipe.sv
// Directed and randomised checks of the Sobel gradient pipeline.
// Window pixel (r,c) sits at bits [(3r+c)*8 +: 8].
module tb_sobel_grad_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] win;
  logic [1:0]  mode;
  logic [7:0]  thr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_pix;
  logic        out_valid;
  logic        out_ready;
  logic        clr;
  logic [19:0] edge_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  logic [71:0] s_win  [1000];
  logic [1:0]  s_mode [1000];
  logic [7:0]  s_thr  [1000];
  logic [7:0]  o_pix  [$];

  always #5 clk = ~clk;

  sobel_grad_pipe #(
    .PIXEL_WIDTH_IN  (8),
    .PIXEL_WIDTH_OUT (8),
    .CNT_WIDTH       (20)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .win_i       (win),
    .mode_i      (mode),
    .thresh_i    (thr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_pix_o   (out_pix),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .clr_cnt_i   (clr),
    .edge_cnt_o  (edge_cnt)
  );

  function automatic logic [71:0] mkwin(input int a00, a01, a02,
                                        input int a10, a11, a12,
                                        input int a20, a21, a22);
    int a [9];
    logic [71:0] w;
    a = '{a00, a01, a02, a10, a11, a12, a20, a21, a22};
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = a[i][7:0];
    return w;
  endfunction

  function automatic void model(input logic [71:0] w, input logic [1:0] m,
                                input logic [7:0] t,
                                output logic [7:0] px, output bit h);
    int p [3][3];
    int gx, gy, ax, ay, mg, st;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = int'(w[(3*r+c)*8 +: 8]);
    gx = (p[0][2]-p[0][0]) + 2*(p[1][2]-p[1][0]) + (p[2][2]-p[2][0]);
    gy = (p[2][0]-p[0][0]) + 2*(p[2][1]-p[0][1]) + (p[2][2]-p[0][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mg = (m == 2'd1) ? ((ax > ay) ? ax : ay) : ax + ay;
    st = (mg > 255) ? 255 : mg;
    h  = (st >= int'(t));
    px = (m == 2'd2) ? (h ? 8'hff : 8'h00) : st[7:0];
  endfunction

  // Single window into an empty pipe; returns result and accept-to-valid edges.
  task automatic xfer(input logic [71:0] w, input logic [1:0] m,
                      input logic [7:0] t,
                      output logic [7:0] px, output int lat);
    @(negedge clk);
    win = w; mode = m; thr = t;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    px = out_pix;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stream(input int n, input int pv, input int pr,
                        output int cyc);
    int idx;
    bit fin, fout, stall;
    logic [7:0] px, held;
    idx = 0; cyc = 0; stall = 0; held = '0;
    o_pix.delete();
    while (o_pix.size() < n && cyc < n * 20 + 50) begin
      @(negedge clk);
      in_valid = (idx < n) && ($urandom_range(0, 99) < pv);
      if (idx < n) begin
        win = s_win[idx]; mode = s_mode[idx]; thr = s_thr[idx];
      end
      out_ready = ($urandom_range(0, 99) < pr);
      #1;
      if (stall) begin
        n_vec++;
        if (!out_valid || out_pix !== held) begin
          n_bad++;
          $display("FAIL hold_stable: got v=%0b pix=%0d want v=1 pix=%0d",
                   out_valid, out_pix, held);
        end
      end
      fin   = in_valid && in_ready;
      fout  = out_valid && out_ready;
      stall = out_valid && !out_ready;
      px    = out_pix;
      held  = out_pix;
      @(posedge clk);
      if (fin)  idx++;
      if (fout) o_pix.push_back(px);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if (out_pix !== 8'd0) begin
      n_bad++; $display("FAIL reset_pix: got %0d want 0", out_pix);
    end
    n_vec++;
    if (edge_cnt !== 20'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", edge_cnt);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    exp_cnt = 0;
  endtask

  task automatic test_uniform();
    logic [7:0] px;
    int lat;
    xfer(mkwin(128,128,128, 128,128,128, 128,128,128), 2'd0, 8'd1, px, lat);
    n_vec++;
    if (px !== 8'd0) begin
      n_bad++; $display("FAIL uniform_pix: got %0d want 0", px);
    end
    n_vec++;
    if (lat !== 3) begin
      n_bad++; $display("FAIL uniform_latency: got %0d want 3", lat);
    end
    n_vec++;
    if (edge_cnt !== 20'd0) begin
      n_bad++; $display("FAIL uniform_cnt: got %0d want 0", edge_cnt);
    end
  endtask

  task automatic test_gx40();
    logic [7:0] px;
    int lat;
    logic [71:0] w;
    w = mkwin(0,77,10, 0,77,10, 0,77,10);
    xfer(w, 2'd0, 8'd40, px, lat);
    n_vec++;
    if (px !== 8'd40) begin
      n_bad++; $display("FAIL gx40_l1: got %0d want 40", px);
    end
    xfer(w, 2'd2, 8'd40, px, lat);
    n_vec++;
    if (px !== 8'd255) begin
      n_bad++; $display("FAIL gx40_thr40: got %0d want 255", px);
    end
    xfer(w, 2'd2, 8'd41, px, lat);
    n_vec++;
    if (px !== 8'd0) begin
      n_bad++; $display("FAIL gx40_thr41: got %0d want 0", px);
    end
    n_vec++;
    if (edge_cnt !== 20'd2) begin
      n_bad++; $display("FAIL gx40_cnt: got %0d want 2", edge_cnt);
    end
    xfer(w, 2'd3, 8'd255, px, lat);
    n_vec++;
    if (px !== 8'd40) begin
      n_bad++; $display("FAIL gx40_rsvd: got %0d want 40", px);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] px;
    int lat;
    xfer(mkwin(0,0,255, 0,0,255, 0,0,255), 2'd0, 8'd0, px, lat);
    n_vec++;
    if (px !== 8'd255) begin
      n_bad++; $display("FAIL sat_l1: got %0d want 255", px);
    end
    n_vec++;
    if (edge_cnt !== 20'd3) begin
      n_bad++; $display("FAIL sat_cnt: got %0d want 3", edge_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [7:0] want [4];
    want = '{8'd60, 8'd40, 8'd60, 8'd40};
    for (int i = 0; i < 4; i++) begin
      s_win[i]  = mkwin(10,10,20, 7,7,17, 5,5,15);
      s_mode[i] = (i % 2 == 0) ? 2'd0 : 2'd1;
      s_thr[i]  = 8'd255;
    end
    stream(4, 100, 100, cyc);
    n_vec++;
    if (o_pix.size() !== 4) begin
      n_bad++; $display("FAIL b2b_count: got %0d want 4", o_pix.size());
    end
    for (int i = 0; i < 4 && i < o_pix.size(); i++) begin
      n_vec++;
      if (o_pix[i] !== want[i]) begin
        n_bad++; $display("FAIL b2b_pix%0d: got %0d want %0d", i, o_pix[i], want[i]);
      end
    end
    n_vec++;
    if (cyc !== 7) begin
      n_bad++; $display("FAIL b2b_cycles: got %0d want 7", cyc);
    end
    n_vec++;
    if (edge_cnt !== 20'd3) begin
      n_bad++; $display("FAIL b2b_cnt: got %0d want 3", edge_cnt);
    end
  endtask

  task automatic test_backpressure();
    int idx, cyc, base, errs;
    bit fire;
    logic [7:0] got [$];
    logic [7:0] px;
    bit h;
    for (int k = 0; k < 6; k++) s_win[k] = mkwin(0,0,k+1, 0,0,k+1, 0,0,k+1);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1; win = s_win[idx]; mode = 2'd0; thr = 8'd255;
      out_ready = 1'b0;
      #1 fire = in_ready;
      @(posedge clk);
      if (fire) idx++;
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (idx !== 3) begin
      n_bad++; $display("FAIL bp_accepted: got %0d want 3", idx);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_ready: got %b want 0", in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1 if (out_valid) got.push_back(out_pix);
      @(posedge clk);
      @(negedge clk);
    end
    n_vec++;
    if (got.size() !== 3) begin
      n_bad++; $display("FAIL bp_out_count: got %0d want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_vec++;
      if (got[i] !== 8'(4*(i+1))) begin
        n_bad++; $display("FAIL bp_order%0d: got %0d want %0d", i, got[i], 4*(i+1));
      end
    end
    // Random traffic against the reference model.
    base = int'(edge_cnt);
    exp_cnt = base;
    for (int i = 0; i < 1000; i++) begin
      int lim;
      lim = (i % 3 == 0) ? 15 : (i % 3 == 1) ? 63 : 255;
      s_win[i] = mkwin($urandom_range(0,lim), $urandom_range(0,lim), $urandom_range(0,lim),
                       $urandom_range(0,lim), $urandom_range(0,lim), $urandom_range(0,lim),
                       $urandom_range(0,lim), $urandom_range(0,lim), $urandom_range(0,lim));
      s_mode[i] = 2'($urandom_range(0,3));
      s_thr[i]  = 8'($urandom_range(0,255));
    end
    stream(1000, 70, 70, cyc);
    n_vec++;
    if (o_pix.size() !== 1000) begin
      n_bad++; $display("FAIL rand_count: got %0d want 1000", o_pix.size());
    end
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      model(s_win[i], s_mode[i], s_thr[i], px, h);
      if (h) exp_cnt++;
      if (i < o_pix.size()) begin
        n_vec++;
        if (o_pix[i] !== px) begin
          n_bad++; errs++;
          if (errs < 10)
            $display("FAIL rand_pix%0d: got %0d want %0d", i, o_pix[i], px);
        end
      end
    end
    n_vec++;
    if (edge_cnt !== 20'(exp_cnt)) begin
      n_bad++; $display("FAIL rand_cnt: got %0d want %0d", edge_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    int seen, g;
    logic [7:0] px;
    int lat;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b0;
      win = mkwin(0,0,10, 0,0,10, 0,0,10); mode = 2'd0; thr = 8'd0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if (edge_cnt !== 20'd0) begin
      n_bad++; $display("FAIL rst_mid_cnt: got %0d want 0", edge_cnt);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1 if (out_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    n_vec++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL rst_stale: got %0d outputs want 0", seen);
    end
    xfer(mkwin(0,77,10, 0,77,10, 0,77,10), 2'd0, 8'd0, px, lat);
    n_vec++;
    if (edge_cnt !== 20'd1) begin
      n_bad++; $display("FAIL clr_pre_cnt: got %0d want 1", edge_cnt);
    end
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 10) begin
      @(posedge clk);
      @(negedge clk);
      g++;
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL clr_wait: got valid %b want 1", out_valid);
    end
    out_ready = 1'b1; clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    n_vec++;
    if (edge_cnt !== 20'd0) begin
      n_bad++; $display("FAIL clr_priority: got %0d want 0", edge_cnt);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL clr_drained: got %b want 0", out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; win = '0; mode = 2'd0; thr = '0;
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    test_reset();
    test_uniform();
    test_gx40();
    test_saturate();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
